// File: rtl/axi_lite_nn_pkg.sv
// Shared definitions for the AXI4-Lite MLP control block: register indices,
// status bit positions, response codes and the byte-strobe merge helper.
package axi_lite_nn_pkg;

    localparam int ADDR_LSB = 2;

    localparam logic [3:0] REG_WEIGHT   = 4'd0;
    localparam logic [3:0] REG_BIAS     = 4'd1;
    localparam logic [3:0] REG_RESULT   = 4'd2;
    localparam logic [3:0] REG_LAYER    = 4'd3;
    localparam logic [3:0] REG_NEURON   = 4'd4;
    localparam logic [3:0] REG_EXT_RD   = 4'd5;
    localparam logic [3:0] REG_STATUS   = 4'd6;
    localparam logic [3:0] REG_CONTROL  = 4'd7;
    localparam logic [3:0] REG_IRQ_EN   = 4'd8;
    localparam logic [3:0] REG_IRQ_STAT = 4'd9;

    localparam int STAT_NOT_EMPTY = 0;
    localparam int STAT_FULL      = 1;
    localparam int STAT_OVERFLOW  = 2;
    localparam int STAT_COUNT_LSB = 8;
    localparam int STAT_COUNT_W   = 9;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    function automatic logic [31:0] apply_strobe(input logic [31:0] old_val,
                                                 input logic [31:0] new_val,
                                                 input logic [3:0]  strb);
        logic [31:0] res;
        res = old_val;
        for (int i = 0; i < 4; i++) begin
            if (strb[i]) begin
                res[i*8 +: 8] = new_val[i*8 +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/axi_lite_nn_ctrl_fifo.sv
// nn_out_fifo: synchronous result FIFO with occupancy count, sticky overflow
// and flush. A pop on empty is ignored; push+pop while full is accepted.
module nn_out_fifo #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 8,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] head_data,
    output logic [CW-1:0]     count,
    output logic              full,
    output logic              empty,
    output logic              overflow
);

    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [AW-1:0]     wr_ptr_r;
    logic [AW-1:0]     rd_ptr_r;
    logic [CW-1:0]     count_r;
    logic              overflow_r;
    logic              full_s;
    logic              empty_s;
    logic              do_push_s;
    logic              do_pop_s;

    // Qualify push/pop; flush suppresses both
    always_comb begin
        full_s    = (count_r == CW'(DEPTH));
        empty_s   = (count_r == '0);
        do_pop_s  = pop && !flush && !empty_s;
        do_push_s = push && !flush && (!full_s || do_pop_s);
    end

    // Storage array, written only on an accepted push
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    // Pointers, occupancy and sticky overflow
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r   <= '0;
            rd_ptr_r   <= '0;
            count_r    <= '0;
            overflow_r <= 1'b0;
        end else if (flush) begin
            wr_ptr_r   <= '0;
            rd_ptr_r   <= '0;
            count_r    <= '0;
            overflow_r <= 1'b0;
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
            if (push && full_s && !do_pop_s) begin
                overflow_r <= 1'b1;
            end
        end
    end

    assign head_data = mem_r[rd_ptr_r];
    assign count     = count_r;
    assign full      = full_s;
    assign empty     = empty_s;
    assign overflow  = overflow_r;

endmodule

// File: rtl/axi_lite_nn_ctrl.sv
// AXI4-Lite register block for the MLP datapath with a buffered result FIFO.
// Optional interrupt logic is enabled by defining AXI_LITE_NN_IRQ_EN.
module axi_lite_nn_ctrl
    import axi_lite_nn_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 6,
    parameter int NN_OUT_WIDTH       = 32,
    parameter int OUT_FIFO_DEPTH     = 8
) (
    input  logic                            S_AXI_ACLK,
    input  logic                            S_AXI_ARESET,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [2:0]                      S_AXI_AWPROT,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [2:0]                      S_AXI_ARPROT,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY,
    output logic [31:0]                     layerNumber,
    output logic [31:0]                     neuronNumber,
    output logic [31:0]                     weightValue,
    output logic [31:0]                     biasValue,
    output logic                            weightValid,
    output logic                            biasValid,
    input  logic [NN_OUT_WIDTH-1:0]         nnOut,
    input  logic                            nnOut_valid,
    output logic                            axi_rd_en,
    input  logic [31:0]                     axi_rd_data,
    output logic                            softReset,
    output logic                            irq
);

    localparam int FIFO_CW = $clog2(OUT_FIFO_DEPTH) + 1;

    logic              aw_ready_r, b_valid_r, ar_ready_r, r_valid_r;
    logic [1:0]        b_resp_r, r_resp_r;
    logic [31:0]       r_data_r;
    logic              rd_ext_pend_r, axi_rd_en_r;
    logic              weight_valid_r, bias_valid_r, soft_reset_r;
    logic [31:0]       weight_r, bias_r, layer_r, neuron_r;
    logic [3:0]        wr_idx_s, rd_idx_s;
    logic              wr_fire_s, rd_fire_s, wr_ok_s, any_strb_s, flush_s, pop_s;
    logic [31:0]       rd_data_s, status_s;
    logic [1:0]        rd_resp_s;
    logic [NN_OUT_WIDTH-1:0] fifo_head_s;
    logic [FIFO_CW-1:0]      fifo_count_s;
    logic              fifo_full_s, fifo_empty_s, fifo_overflow_s;
    logic              unused_s;

    assign wr_idx_s   = S_AXI_AWADDR[ADDR_LSB +: 4];
    assign rd_idx_s   = S_AXI_ARADDR[ADDR_LSB +: 4];
    assign wr_fire_s  = aw_ready_r && S_AXI_AWVALID && S_AXI_WVALID;
    assign rd_fire_s  = ar_ready_r && S_AXI_ARVALID;
    assign any_strb_s = |S_AXI_WSTRB;
    assign flush_s    = wr_fire_s && wr_ok_s && (wr_idx_s == REG_CONTROL) &&
                        S_AXI_WSTRB[0] && S_AXI_WDATA[1];
    assign pop_s      = rd_fire_s && (rd_idx_s == REG_RESULT);
    assign unused_s   = ^{S_AXI_AWPROT, S_AXI_ARPROT,
                          S_AXI_AWADDR[ADDR_LSB-1:0], S_AXI_ARADDR[ADDR_LSB-1:0]};

    nn_out_fifo #(
        .DATA_W (NN_OUT_WIDTH),
        .DEPTH  (OUT_FIFO_DEPTH)
    ) u_fifo (
        .clk       (S_AXI_ACLK),
        .rst       (S_AXI_ARESET),
        .flush     (flush_s),
        .push      (nnOut_valid),
        .push_data (nnOut),
        .pop       (pop_s),
        .head_data (fifo_head_s),
        .count     (fifo_count_s),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s),
        .overflow  (fifo_overflow_s)
    );

    // Status word assembly
    always_comb begin
        status_s = 32'h0000_0000;
        status_s[STAT_NOT_EMPTY] = !fifo_empty_s;
        status_s[STAT_FULL]      = fifo_full_s;
        status_s[STAT_OVERFLOW]  = fifo_overflow_s;
        status_s[STAT_COUNT_LSB +: STAT_COUNT_W] = STAT_COUNT_W'(fifo_count_s);
    end

`ifdef AXI_LITE_NN_IRQ_EN
    logic [1:0] irq_en_r, irq_stat_r, irq_set_s, irq_clr_s;
    logic       not_empty_d_r, overflow_d_r, irq_r;

    // Edge-detected set events and write-one-to-clear mask
    always_comb begin
        irq_set_s = {fifo_overflow_s && !overflow_d_r, !fifo_empty_s && !not_empty_d_r};
        if (wr_fire_s && (wr_idx_s == REG_IRQ_STAT) && S_AXI_WSTRB[0]) begin
            irq_clr_s = S_AXI_WDATA[1:0];
        end else begin
            irq_clr_s = 2'b00;
        end
    end

    // Interrupt enable, sticky status (set wins over clear) and registered irq
    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            irq_en_r      <= 2'b00;
            irq_stat_r    <= 2'b00;
            not_empty_d_r <= 1'b0;
            overflow_d_r  <= 1'b0;
            irq_r         <= 1'b0;
        end else begin
            if (wr_fire_s && (wr_idx_s == REG_IRQ_EN) && S_AXI_WSTRB[0]) begin
                irq_en_r <= S_AXI_WDATA[1:0];
            end
            not_empty_d_r <= !fifo_empty_s;
            overflow_d_r  <= fifo_overflow_s;
            irq_stat_r    <= irq_set_s | (irq_stat_r & ~irq_clr_s);
            irq_r         <= |(irq_stat_r & irq_en_r);
        end
    end

    assign irq = irq_r;
`else
    assign irq = 1'b0;
`endif

    // Write decode: which indices accept a write
    always_comb begin
        case (wr_idx_s)
            REG_WEIGHT, REG_BIAS, REG_LAYER, REG_NEURON, REG_CONTROL: wr_ok_s = 1'b1;
`ifdef AXI_LITE_NN_IRQ_EN
            REG_IRQ_EN, REG_IRQ_STAT: wr_ok_s = 1'b1;
`endif
            default: wr_ok_s = 1'b0;
        endcase
    end

    // Read mux; an empty result pop reads zero with OKAY
    always_comb begin
        rd_resp_s = RESP_OKAY;
        case (rd_idx_s)
            REG_WEIGHT:  rd_data_s = weight_r;
            REG_BIAS:    rd_data_s = bias_r;
            REG_RESULT:  rd_data_s = fifo_empty_s ? 32'h0000_0000 : 32'(fifo_head_s);
            REG_LAYER:   rd_data_s = layer_r;
            REG_NEURON:  rd_data_s = neuron_r;
            REG_EXT_RD:  rd_data_s = axi_rd_data;
            REG_STATUS:  rd_data_s = status_s;
            REG_CONTROL: rd_data_s = {31'h0000_0000, soft_reset_r};
`ifdef AXI_LITE_NN_IRQ_EN
            REG_IRQ_EN:   rd_data_s = {30'h0000_0000, irq_en_r};
            REG_IRQ_STAT: rd_data_s = {30'h0000_0000, irq_stat_r};
`endif
            default: begin
                rd_data_s = 32'h0000_0000;
                rd_resp_s = RESP_SLVERR;
            end
        endcase
    end

    // AXI handshakes: one write and one read outstanding at a time
    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            aw_ready_r    <= 1'b0;
            b_valid_r     <= 1'b0;
            b_resp_r      <= RESP_OKAY;
            ar_ready_r    <= 1'b0;
            r_valid_r     <= 1'b0;
            r_resp_r      <= RESP_OKAY;
            r_data_r      <= 32'h0000_0000;
            rd_ext_pend_r <= 1'b0;
            axi_rd_en_r   <= 1'b0;
        end else begin
            aw_ready_r <= S_AXI_AWVALID && S_AXI_WVALID && !aw_ready_r && !b_valid_r;
            if (wr_fire_s) begin
                b_valid_r <= 1'b1;
                b_resp_r  <= wr_ok_s ? RESP_OKAY : RESP_SLVERR;
            end else if (S_AXI_BREADY) begin
                b_valid_r <= 1'b0;
            end
            ar_ready_r <= S_AXI_ARVALID && !ar_ready_r && !r_valid_r;
            if (rd_fire_s) begin
                r_valid_r     <= 1'b1;
                r_data_r      <= rd_data_s;
                r_resp_r      <= rd_resp_s;
                rd_ext_pend_r <= (rd_idx_s == REG_EXT_RD);
            end else if (S_AXI_RREADY) begin
                r_valid_r <= 1'b0;
            end
            axi_rd_en_r <= r_valid_r && S_AXI_RREADY && rd_ext_pend_r;
        end
    end

    // Configuration registers with byte strobes and one-cycle valid pulses
    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            weight_r       <= 32'h0000_0000;
            bias_r         <= 32'h0000_0000;
            layer_r        <= 32'h0000_0000;
            neuron_r       <= 32'h0000_0000;
            soft_reset_r   <= 1'b0;
            weight_valid_r <= 1'b0;
            bias_valid_r   <= 1'b0;
        end else begin
            weight_valid_r <= 1'b0;
            bias_valid_r   <= 1'b0;
            if (wr_fire_s && wr_ok_s) begin
                case (wr_idx_s)
                    REG_WEIGHT: begin
                        weight_r       <= apply_strobe(weight_r, S_AXI_WDATA, S_AXI_WSTRB);
                        weight_valid_r <= any_strb_s;
                    end
                    REG_BIAS: begin
                        bias_r       <= apply_strobe(bias_r, S_AXI_WDATA, S_AXI_WSTRB);
                        bias_valid_r <= any_strb_s;
                    end
                    REG_LAYER:  layer_r  <= apply_strobe(layer_r, S_AXI_WDATA, S_AXI_WSTRB);
                    REG_NEURON: neuron_r <= apply_strobe(neuron_r, S_AXI_WDATA, S_AXI_WSTRB);
                    REG_CONTROL: begin
                        if (S_AXI_WSTRB[0]) begin
                            soft_reset_r <= S_AXI_WDATA[0];
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign S_AXI_AWREADY = aw_ready_r;
    assign S_AXI_WREADY  = aw_ready_r;
    assign S_AXI_BVALID  = b_valid_r;
    assign S_AXI_BRESP   = b_resp_r;
    assign S_AXI_ARREADY = ar_ready_r;
    assign S_AXI_RVALID  = r_valid_r;
    assign S_AXI_RRESP   = r_resp_r;
    assign S_AXI_RDATA   = r_data_r;
    assign weightValue   = weight_r;
    assign biasValue     = bias_r;
    assign layerNumber   = layer_r;
    assign neuronNumber  = neuron_r;
    assign weightValid   = weight_valid_r;
    assign biasValid     = bias_valid_r;
    assign softReset     = soft_reset_r;
    assign axi_rd_en     = axi_rd_en_r;

endmodule

// File: doc/axi_lite_nn_ctrl.md
Name: axi_lite_nn_ctrl

Overview:
Parametrised AXI4-Lite slave register block between the host and the MLP datapath. Drives weight/bias/layer/neuron configuration and soft reset. Buffers inference results in an internal output FIFO instead of a single overwrite register. Adds byte-strobe writes, SLVERR on unmapped addresses, occupancy/overflow status and an optional interrupt.

Parameters:
C_S_AXI_DATA_WIDTH, 32, AXI data width (fixed at 32; other values unsupported).
C_S_AXI_ADDR_WIDTH, 6, byte address width; covers 16 word registers.
NN_OUT_WIDTH, 32, width of nnOut; zero-extended to 32 bits on read.
OUT_FIFO_DEPTH, 8, result FIFO depth; power of two, 2..256.

Ports:
S_AXI_ACLK  in  1  clock
S_AXI_ARESET  in  1  asynchronous active-high reset
S_AXI_AWADDR/AWPROT/AWVALID/AWREADY, WDATA/WSTRB/WVALID/WREADY, BRESP/BVALID/BREADY, ARADDR/ARPROT/ARVALID/ARREADY, RDATA/RRESP/RVALID/RREADY  standard AXI4-Lite, widths per parameters; PROT ignored
layerNumber  out  32  layer register
neuronNumber  out  32  neuron register
weightValue  out  32  weight register
biasValue  out  32  bias register
weightValid  out  1  one-cycle pulse on weight write
biasValid  out  1  one-cycle pulse on bias write
nnOut  in  NN_OUT_WIDTH  inference result
nnOut_valid  in  1  push nnOut into FIFO
axi_rd_en  out  1  one-cycle pulse after completed read of reg 5
axi_rd_data  in  32  external readback data
softReset  out  1  control[0]
irq  out  1  interrupt (AXI_LITE_NN_IRQ_EN only; otherwise tied 0)

Behaviour:
- Register map (word index = ADDR[5:2]): 0 weight RW, 1 bias RW, 2 result RO (pop), 3 layer RW, 4 neuron RW, 5 ext-read RO, 6 status RO, 7 control RW, 8 irq_enable RW, 9 irq_status W1C. Indices 10-15 unmapped.
- Reset: all registers, FIFO pointers/count, overflow, AWREADY/WREADY/BVALID/ARREADY/RVALID, pulses and irq = 0. RDATA = 0, BRESP/RRESP = OKAY.
- Write channel:
  - AWREADY and WREADY assert together for one cycle when AWVALID && WVALID && no B response pending.
  - Register update happens in that cycle; BVALID rises the next cycle and holds until BREADY.
  - Only one write outstanding at a time.
  - BRESP = SLVERR (2'b10) for unmapped or read-only indices, with no side effects; otherwise OKAY.
- WSTRB: each byte lane is written only if its strobe is set. weightValid/biasValid pulse the cycle after acceptance if any strobe is set.
- Read channel:
  - ARREADY pulses for one cycle when ARVALID is high and no R beat is pending.
  - RDATA is registered; RVALID asserts the next cycle and holds until RREADY.
  - RRESP = SLVERR and RDATA = 0 for unmapped indices.
- Result FIFO:
  - nnOut_valid pushes nnOut.
  - Read acceptance of reg 2 pops the head; RDATA = head.
  - Empty pop: RDATA = 0, no pointer change, RRESP OKAY.
  - Push when full with no same-cycle pop: data dropped, overflow sticky set.
  - Simultaneous push and pop: both occur, count unchanged, valid also when full.
  - Read-first semantics: a pop returns the old head.
- Status (reg 6): bit0 not_empty, bit1 full, bit2 overflow, bits[16:8] count; other bits 0.
- Control (reg 7): bit0 softReset (level); bit1 written 1 = flush FIFO and clear overflow (self-clearing, reads 0).
- Ext read: axi_rd_en pulses one cycle when an R beat for index 5 completes (RVALID && RREADY).
- softReset does not reset this block.
- Reset asserted mid-transaction: all handshake outputs drop immediately. The master must restart the transaction.

Optional Feature:
AXI_LITE_NN_IRQ_EN:
- Defined: irq_status bit0 sets on a not_empty rising edge; bit1 sets when overflow is set.
- irq = |(irq_status & irq_enable), registered.
- Writing 1 to an irq_status bit clears it; a set event in the same cycle wins.
- Undefined: regs 8/9 are unmapped (SLVERR) and irq = 0.

Decomposition:
- Shared package axi_lite_nn_pkg holds:
  - register index localparams (REG_WEIGHT..REG_IRQ_STAT)
  - status bit positions
  - RESP_OKAY / RESP_SLVERR
  - ADDR_LSB = 2
- One sub-module, nn_out_fifo: synchronous FIFO with count, full, empty, overflow and flush.

Test Plan:
- Write 0xA5A5_1234 to 0x00 with WSTRB=4'hF -> weightValue = 0xA5A5_1234, single weightValid pulse, BRESP OKAY.
- Write 0xFFFF_FFFF to 0x0C with WSTRB=4'b0010 after layer = 0 -> layerNumber = 0x0000_FF00.
- Push 3 results (1,2,3); read 0x18 -> 0x0000_0301. Read 0x08 three times -> 1,2,3. Fourth read -> 0, status = 0.
- Push 9 results with DEPTH=8 -> status full=1, overflow=1, count=8. Write control bit1 -> status = 0.
- Read 0x28 (index 10) -> RRESP SLVERR, RDATA 0. Write 0x08 -> BRESP SLVERR, FIFO unchanged.
- IRQ_EN build: irq_enable = 1, push one result -> irq rises within 2 cycles. Write 1 to 0x24 -> irq drops.
